// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared types and operand-select encodings for the modular-exponentiation sequencer.
package rsa_modexp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_X,
        S_PRE_ACC,
        S_SQUARE,
        S_MULT,
        S_POST,
        S_DONE
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    localparam logic [1:0] A_ACC   = 2'd0;
    localparam logic [1:0] A_PLAIN = 2'd1;
    localparam logic [1:0] A_ONE   = 2'd2;

    localparam logic [1:0] B_ACC   = 2'd0;
    localparam logic [1:0] B_XBAR  = 2'd1;
    localparam logic [1:0] B_R2    = 2'd2;
    localparam logic [1:0] B_ONE   = 2'd3;

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// Host control and Montgomery-multiplier handshake bundle for rsa_modexp_ctrl.
interface rsa_modexp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] exponent;
    logic             mmm_start;
    logic             mmm_done;
    logic             mmm_clr;
    logic [1:0]       a_sel;
    logic [1:0]       b_sel;
    logic             acc_we;
    logic             xbar_we;
    logic             busy;
    logic             eoc;

    // master: the surrounding system (host + multiplier); slave: the sequencer
    modport master (
        output ena, start, stop, exponent, mmm_done,
        input  mmm_start, mmm_clr, a_sel, b_sel, acc_we, xbar_we, busy, eoc
    );

    modport slave (
        input  ena, start, stop, exponent, mmm_done,
        output mmm_start, mmm_clr, a_sel, b_sel, acc_we, xbar_we, busy, eoc
    );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery multiplier,
// including Montgomery-domain entry (PRE_X, PRE_ACC) and exit (POST).
module rsa_modexp_ctrl
    import rsa_modexp_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    rsa_modexp_ctrl_if.slave  bus
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] exp_q, exp_d;

    logic       start_pls, clr_pls, acc_we_s, xbar_we_s, eoc_s;
    logic [1:0] a_sel_s, b_sel_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_ISSUE;
            bit_idx_q <= IDX_TOP;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            exp_q     <= exp_d;
        end
    end

    // Operand selects depend on the state only, so they are stable across ISSUE and WAIT
    always_comb begin
        a_sel_s = A_ACC;
        b_sel_s = B_ACC;
        case (state_q)
            S_PRE_X:   begin a_sel_s = A_PLAIN; b_sel_s = B_R2;   end
            S_PRE_ACC: begin a_sel_s = A_ONE;   b_sel_s = B_R2;   end
            S_SQUARE:  begin a_sel_s = A_ACC;   b_sel_s = B_ACC;  end
            S_MULT:    begin a_sel_s = A_ACC;   b_sel_s = B_XBAR; end
            S_POST:    begin a_sel_s = A_ACC;   b_sel_s = B_ONE;  end
            default:   begin a_sel_s = A_ACC;   b_sel_s = B_ACC;  end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        exp_d     = exp_q;
        start_pls = 1'b0;
        clr_pls   = 1'b0;
        acc_we_s  = 1'b0;
        xbar_we_s = 1'b0;
        eoc_s     = 1'b0;

        if (bus.ena) begin
            if (state_q == S_IDLE) begin
                if (bus.start && !bus.stop) begin
                    state_d   = S_PRE_X;
                    phase_d   = PH_ISSUE;
                    exp_d     = bus.exponent;
                    bit_idx_d = IDX_TOP;
                end
            end else if (bus.stop) begin
                // Abort outranks a coincident mmm_done: no write strobe, no eoc
                state_d = S_IDLE;
                phase_d = PH_ISSUE;
                clr_pls = 1'b1;
            end else if (state_q == S_DONE) begin
                eoc_s   = 1'b1;
                state_d = S_IDLE;
            end else if (phase_q == PH_ISSUE) begin
                start_pls = 1'b1;
                phase_d   = PH_WAIT;
            end else if (bus.mmm_done) begin
                phase_d = PH_ISSUE;
                case (state_q)
                    S_PRE_X: begin
                        xbar_we_s = 1'b1;
                        state_d   = S_PRE_ACC;
                    end
                    S_PRE_ACC: begin
                        acc_we_s = 1'b1;
                        state_d  = S_SQUARE;
                    end
                    S_SQUARE: begin
                        acc_we_s = 1'b1;
                        if (exp_q[bit_idx_q]) begin
                            state_d = S_MULT;
                        end else if (bit_idx_q == '0) begin
                            state_d = S_POST;
                        end else begin
                            bit_idx_d = bit_idx_q - IDX_W'(1);
                            state_d   = S_SQUARE;
                        end
                    end
                    S_MULT: begin
                        acc_we_s = 1'b1;
                        if (bit_idx_q == '0) begin
                            state_d = S_POST;
                        end else begin
                            bit_idx_d = bit_idx_q - IDX_W'(1);
                            state_d   = S_SQUARE;
                        end
                    end
                    S_POST: begin
                        acc_we_s = 1'b1;
                        state_d  = S_DONE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    assign bus.mmm_start = start_pls;
    assign bus.mmm_clr   = clr_pls;
    assign bus.acc_we    = acc_we_s;
    assign bus.xbar_we   = xbar_we_s;
    assign bus.eoc       = eoc_s;
    assign bus.a_sel     = a_sel_s;
    assign bus.b_sel     = b_sel_s;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench: mock Montgomery multiplier plus a plain modular-power reference.
module tb_rsa_modexp_ctrl;
    import rsa_modexp_ctrl_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rsa_modexp_ctrl_if #(.WIDTH(W)) bus();

    rsa_modexp_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // ---------------- mock multiplier (values in Montgomery form, R = 2^W) ----------------
    longint nmod = 3, mplain = 0, r2 = 1, rinv = 1;
    longint acc_reg = 0, xbar_reg = 0, res_reg = 0;
    int     k_lat = 1;
    int     cyc = 0;
    int     done_cyc = 0;
    bit     pending = 1'b0;

    function automatic longint mont(input longint a, input longint b);
        return (((a * b) % nmod) * rinv) % nmod;
    endfunction

    function automatic longint op_a(input logic [1:0] s);
        case (s)
            A_ACC:   return acc_reg;
            A_PLAIN: return mplain;
            A_ONE:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic longint op_b(input logic [1:0] s);
        case (s)
            B_ACC:   return acc_reg;
            B_XBAR:  return xbar_reg;
            B_R2:    return r2;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.mmm_done = !rst && pending && (cyc == done_cyc);
    end

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (bus.ena && bus.acc_we)  acc_reg  = res_reg;
            if (bus.ena && bus.xbar_we) xbar_reg = res_reg;
            if (bus.mmm_clr || (bus.mmm_done && bus.ena)) pending = 1'b0;
            if (bus.mmm_start) begin
                res_reg  = mont(op_a(bus.a_sel), op_b(bus.b_sel));
                pending  = 1'b1;
                done_cyc = cyc + k_lat;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        longint result;
        int     nops;
        int     k;
    } exp_t;

    exp_t       res_q[$];
    logic [3:0] ops_q[$];

    bit run_active = 1'b0;
    int acc_cyc = 0, n_start = 0, n_acc = 0, n_xbar = 0, busy_low = 0, ena_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            run_active = 1'b0;
        end else begin
            if (!bus.busy && bus.start && !bus.stop && bus.ena) begin
                run_active = 1'b1;
                acc_cyc    = cyc;
                n_start    = 0;
                n_acc      = 0;
                n_xbar     = 0;
                busy_low   = 0;
                ena_low    = 0;
            end else if (run_active) begin
                if (!bus.busy) busy_low++;
                if (!bus.ena)  ena_low++;
            end
            if (!bus.ena)
                check("no_pulse_ena_low",
                      {bus.mmm_start, bus.acc_we, bus.xbar_we, bus.eoc, bus.mmm_clr}, 0);
            if (bus.mmm_start) begin
                n_start++;
                check("start_expected", ops_q.size() > 0, 1);
                if (ops_q.size() > 0) check("op_sel", {bus.a_sel, bus.b_sel}, ops_q.pop_front());
            end
            if (bus.acc_we)  n_acc++;
            if (bus.xbar_we) n_xbar++;
            if (bus.mmm_clr) run_active = 1'b0;
            if (bus.eoc) begin
                check("eoc_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    exp_t e;
                    e = res_q.pop_front();
                    check("result",     acc_reg,     e.result);
                    check("op_count",   n_start,     e.nops);
                    check("acc_we_cnt", n_acc,       e.nops - 1);
                    check("xbar_we_cnt", n_xbar,     1);
                    check("busy_gap",   busy_low,    0);
                    check("latency",    cyc - acc_cyc, e.nops * (e.k + 1) + 1 + ena_low);
                end
                run_active = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic longint ref_pow(input longint m, input int e, input longint n);
        longint r;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setup_operands();
        nmod   = longint'($urandom_range(1, 127)) * 2 + 1;
        mplain = longint'($urandom_range(0, 32'(nmod - 1)));
        r2     = (longint'(1) << (2 * W)) % nmod;
        for (longint x = 1; x < nmod; x++)
            if (((longint'(1) << W) * x) % nmod == 1) rinv = x;
        acc_reg  = longint'($urandom_range(0, 255));
        xbar_reg = longint'($urandom_range(0, 255));
    endtask

    task automatic launch(input logic [W-1:0] e, input bit expect_eoc);
        exp_t x;
        ops_q.push_back({A_PLAIN, B_R2});
        ops_q.push_back({A_ONE, B_R2});
        for (int i = W - 1; i >= 0; i--) begin
            ops_q.push_back({A_ACC, B_ACC});
            if (e[i]) ops_q.push_back({A_ACC, B_XBAR});
        end
        ops_q.push_back({A_ACC, B_ONE});
        if (expect_eoc) begin
            x.result = ref_pow(mplain, int'(e), nmod);
            x.nops   = 3 + W + $countones(e);
            x.k      = k_lat;
            res_q.push_back(x);
        end
        bus.exponent = e;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.exponent = W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (res_q.size() == 0 && !bus.busy) break;
            step();
        end
        check("run_completes", (res_q.size() == 0) && !bus.busy, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ena      = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.exponent = '0;
        setup_operands();
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {bus.busy, bus.mmm_start, bus.mmm_clr, bus.acc_we, bus.xbar_we,
                                bus.eoc, bus.a_sel, bus.b_sel}, 0);
        rst = 1'b0;
        step();

        // sparse exponent, k=3
        k_lat = 3; setup_operands(); launch(8'h05, 1'b1); wait_done();
        // zero exponent, k=1
        k_lat = 1; setup_operands(); launch(8'h00, 1'b1); wait_done();
        // dense exponent
        k_lat = 2; setup_operands(); launch(8'hFF, 1'b1); wait_done();

        for (int r = 0; r < 8; r++) begin
            k_lat = int'($urandom_range(1, 4));
            setup_operands();
            launch(W'($urandom), 1'b1);
            wait_done();
        end

        // abort during the WAIT of the 4th operation, coincident with mmm_done
        k_lat = 3; setup_operands(); launch(8'hA7, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (n_start >= 4) break;
            step();
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.mmm_done) break;
            step();
        end
        check("abort_done_present", bus.mmm_done, 1);
        bus.stop = 1'b1;
        #1;
        check("abort_clr", bus.mmm_clr, 1);
        check("abort_no_strobe", {bus.acc_we, bus.xbar_we, bus.eoc}, 0);
        step();
        bus.stop = 1'b0;
        check("abort_idle", bus.busy, 0);
        ops_q.delete();
        repeat (10) step();

        // start+stop together stays idle; start while busy is ignored
        bus.exponent = 8'h33;
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_idle", bus.busy, 0);
        k_lat = 2; setup_operands(); launch(8'h5A, 1'b1);
        repeat (6) step();
        bus.exponent = 8'hC3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done();

        // ena low for 5 cycles during the first ISSUE
        k_lat = 2; setup_operands(); launch(8'h9C, 1'b1);
        bus.ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("busy_hold_ena_low", bus.busy, 1);
        end
        bus.ena = 1'b1;
        wait_done();

        // asynchronous reset in the middle of a SQUARE
        k_lat = 3; setup_operands(); launch(8'h81, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (n_start >= 3) break;
            step();
        end
        step();
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus.busy, bus.mmm_start, bus.mmm_clr, bus.acc_we, bus.xbar_we,
                                      bus.eoc, bus.a_sel, bus.b_sel}, 0);
        ops_q.delete();
        step();
        rst = 1'b0;
        step();
        k_lat = 1; setup_operands(); launch(8'h3C, 1'b1); wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
